// File: rtl/rgb_led_fader.sv
// RGB LED output stage: per-channel linear brightness fades driven out as active-low PWM.
// Optional macro RGB_LED_FADER_GAMMA_EN squares the level (>>8) before the PWM compare.
module rgb_led_fader #(
   parameter int PWM_DIV  = 47,
   parameter int FADE_DIV = 46875
) (
   input  logic       CLK_IN,
   input  logic       RST,
   input  logic [2:0] PATTERN_IN,
   input  logic [7:0] BRIGHT,
   output logic [2:0] RGB_LED,
   output logic       BUSY
);

   localparam int PW = (PWM_DIV  > 1) ? $clog2(PWM_DIV)  : 1;
   localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_DIV - 1);
   localparam logic [FW-1:0] FADE_LAST = FW'(FADE_DIV - 1);

   typedef enum logic [1:0] {HOLD = 2'd0, UP = 2'd1, DOWN = 2'd2} ch_state_t;

   logic [PW-1:0] pwm_pre;
   logic [FW-1:0] fade_pre;
   logic          pwm_tick;
   logic          fade_tick;
   logic [7:0]    pwm_cnt;
   logic [2:0]    pat_q;
   logic [7:0]    target     [3];
   logic [7:0]    level      [3];
   logic [7:0]    level_next [3];
   logic [7:0]    duty       [3];
   ch_state_t     state      [3];
   ch_state_t     state_next [3];
   logic [2:0]    led_next;
   logic          busy_next;

   assign pwm_tick  = (pwm_pre == PWM_LAST);
   assign fade_tick = (fade_pre == FADE_LAST);

   // Prescalers, PWM counter and the input pattern register
   always_ff @(posedge CLK_IN) begin
      if (RST) begin
         pwm_pre  <= '0;
         fade_pre <= '0;
         pwm_cnt  <= 8'd0;
         pat_q    <= 3'b111;
      end else begin
         pwm_pre  <= pwm_tick  ? '0 : pwm_pre + PW'(1);
         fade_pre <= fade_tick ? '0 : fade_pre + FW'(1);
         pwm_cnt  <= pwm_tick  ? pwm_cnt + 8'd1 : pwm_cnt;
         pat_q    <= PATTERN_IN;
      end
   end

   // Channel FSMs: the level only moves toward target, so it can never overshoot or wrap
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         target[i]     = pat_q[i] ? 8'd0 : BRIGHT;
         state_next[i] = state[i];
         level_next[i] = level[i];
         case (state[i])
            HOLD: begin
               if (target[i] > level[i]) begin
                  state_next[i] = UP;
               end else if (target[i] < level[i]) begin
                  state_next[i] = DOWN;
               end else begin
                  state_next[i] = HOLD;
               end
            end
            UP: begin
               if (target[i] < level[i]) begin
                  state_next[i] = DOWN;
               end else if (target[i] == level[i]) begin
                  state_next[i] = HOLD;
               end else begin
                  state_next[i] = UP;
                  level_next[i] = fade_tick ? level[i] + 8'd1 : level[i];
               end
            end
            DOWN: begin
               if (target[i] > level[i]) begin
                  state_next[i] = UP;
               end else if (target[i] == level[i]) begin
                  state_next[i] = HOLD;
               end else begin
                  state_next[i] = DOWN;
                  level_next[i] = fade_tick ? level[i] - 8'd1 : level[i];
               end
            end
            default: begin
               state_next[i] = HOLD;
            end
         endcase
      end
   end

   // Channel state and level registers
   always_ff @(posedge CLK_IN) begin
      for (int i = 0; i < 3; i++) begin
         if (RST) begin
            state[i] <= HOLD;
            level[i] <= 8'd0;
         end else begin
            state[i] <= state_next[i];
            level[i] <= level_next[i];
         end
      end
   end

`ifdef RGB_LED_FADER_GAMMA_EN
   // Gamma stage: registered square of the level, upper byte kept
   always_ff @(posedge CLK_IN) begin
      for (int i = 0; i < 3; i++) begin
         if (RST) begin
            duty[i] <= 8'd0;
         end else begin
            duty[i] <= 8'(({8'd0, level[i]} * {8'd0, level[i]}) >> 8);
         end
      end
   end
`else
   // Linear mapping: duty follows the level directly
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         duty[i] = level[i];
      end
   end
`endif

   // PWM compare and busy summary feeding the output registers
   always_comb begin
      led_next  = 3'b111;
      busy_next = 1'b0;
      for (int i = 0; i < 3; i++) begin
         led_next[i] = ~(pwm_cnt < duty[i]);
         busy_next   = busy_next | (state_next[i] != HOLD);
      end
   end

   // Output registers; BUSY is aligned with the registered channel states
   always_ff @(posedge CLK_IN) begin
      if (RST) begin
         RGB_LED <= 3'b111;
         BUSY    <= 1'b0;
      end else begin
         RGB_LED <= led_next;
         BUSY    <= busy_next;
      end
   end

endmodule

// File: tb/tb_rgb_led_fader.sv
// Directed, table-driven bench for rgb_led_fader (PWM_DIV=1, FADE_DIV=4).
// Honours RGB_LED_FADER_GAMMA_EN in its duty model.
module tb_rgb_led_fader;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] pattern;
   logic [7:0] bright;
   logic [2:0] rgb_led;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] pat;
      logic [7:0] bri;
      int         l0;
      int         l1;
      int         l2;
   } vec_t;

   vec_t vecs [8];

   rgb_led_fader #(.PWM_DIV(1), .FADE_DIV(4)) dut (
      .CLK_IN    (clk),
      .RST       (rst),
      .PATTERN_IN(pattern),
      .BRIGHT    (bright),
      .RGB_LED   (rgb_led),
      .BUSY      (busy)
   );

   always #5 clk = ~clk;

   function automatic int duty_model(input int lvl);
`ifdef RGB_LED_FADER_GAMMA_EN
      return (lvl * lvl) >> 8;
`else
      return lvl;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_idle(input int bound, output int cyc);
      cyc = 0;
      while (busy !== 1'b0 && cyc < bound) begin
         step();
         cyc++;
      end
   endtask

   task automatic count_lows(input int n, output int lows);
      lows = 0;
      for (int k = 0; k < n; k++) begin
         step();
         if (rgb_led !== 3'b111) lows++;
      end
   endtask

   task automatic measure(output int low0, output int low1, output int low2, output int rises1);
      logic prev;
      low0 = 0; low1 = 0; low2 = 0; rises1 = 0;
      prev = rgb_led[1];
      for (int k = 0; k < 256; k++) begin
         step();
         if (rgb_led[0] === 1'b0) low0++;
         if (rgb_led[1] === 1'b0) low1++;
         if (rgb_led[2] === 1'b0) low2++;
         if (prev === 1'b0 && rgb_led[1] === 1'b1) rises1++;
         prev = rgb_led[1];
      end
   endtask

   initial begin
      int cyc, lows, lo0, lo1, lo2, rises;

      vecs[0] = '{3'b111, 8'd255, 0,   0,   0};
      vecs[1] = '{3'b110, 8'd255, 255, 0,   0};
      vecs[2] = '{3'b101, 8'd64,  0,   64,  0};
      vecs[3] = '{3'b101, 8'd180, 0,   180, 0};
      vecs[4] = '{3'b000, 8'd128, 128, 128, 128};
      vecs[5] = '{3'b011, 8'd1,   0,   0,   1};
      vecs[6] = '{3'b010, 8'd200, 200, 0,   200};
      vecs[7] = '{3'b111, 8'd0,   0,   0,   0};

      // Reset and quiet outputs with everything off
      rst = 1'b1; pattern = 3'b111; bright = 8'd0;
      steps(3);
      check("reset_led", {29'd0, rgb_led}, 32'd7);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      count_lows(300, lows);
      check("reset_no_pulse", lows, 0);

      // Full fade up on red
      bright = 8'd255; pattern = 3'b110;
      steps(2);
      check("fade_busy_rise", {31'd0, busy}, 32'd1);
      wait_idle(1500, cyc);
      check("fade_idle", {31'd0, busy}, 32'd0);
      check("fade_time_ok", ((cyc + 2) >= 1010 && (cyc + 2) <= 1035) ? 1 : 0, 1);
      steps(4);
      measure(lo0, lo1, lo2, rises);
      check("fade_red_low", lo0, duty_model(255));
      check("fade_green_low", lo1, 0);
      check("fade_blue_low", lo2, 0);

      // Back to dark, then reverse a ramp at about level 100
      pattern = 3'b111;
      steps(4);
      wait_idle(1500, cyc);
      check("dark_idle", {31'd0, busy}, 32'd0);
      pattern = 3'b110;
      steps(400);
      check("rev_busy_mid", {31'd0, busy}, 32'd1);
      pattern = 3'b111;
      steps(4);
      wait_idle(1500, cyc);
      check("rev_idle", {31'd0, busy}, 32'd0);
      check("rev_time_ok", ((cyc + 4) >= 385 && (cyc + 4) <= 420) ? 1 : 0, 1);
      count_lows(300, lows);
      check("rev_no_pulse", lows, 0);

      // Reset in the middle of a ramp, then a full ramp from zero
      pattern = 3'b110;
      steps(200);
      rst = 1'b1;
      step();
      check("midrst_led", {29'd0, rgb_led}, 32'd7);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      steps(2);
      check("midrst_led_hold", {29'd0, rgb_led}, 32'd7);
      rst = 1'b0;
      steps(4);
      wait_idle(1500, cyc);
      check("midrst_idle", {31'd0, busy}, 32'd0);
      check("midrst_time_ok", ((cyc + 4) >= 1010 && (cyc + 4) <= 1035) ? 1 : 0, 1);

      // Settled duty per colour/brightness vector
      for (int i = 0; i < 8; i++) begin
         pattern = vecs[i].pat;
         bright  = vecs[i].bri;
         steps(4);
         wait_idle(1600, cyc);
         check($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
         steps(4);
         measure(lo0, lo1, lo2, rises);
         check($sformatf("v%0d_ch0", i), lo0, duty_model(vecs[i].l0));
         check($sformatf("v%0d_ch1", i), lo1, duty_model(vecs[i].l1));
         check($sformatf("v%0d_ch2", i), lo2, duty_model(vecs[i].l2));
         check($sformatf("v%0d_ch1_runs", i), rises, (duty_model(vecs[i].l1) > 0) ? 1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
